rs232_rx_fifo: RTL and testbench
================================

// Module: rs232_rx_fifo
// PURPOSE
//  Parametrised RS232 receiver: 5..9 data bits, optional even/odd parity, 1 or 2 stop bits,
//  and a run-time bit-period divisor. Each frame writes data plus error flags into a
//  FIFO_DEPTH-entry receive FIFO. It sits on the I/O bus in place of the fixed 8N1 receiver;
//  software reads the FIFO head and acknowledges it with done.
// PARAMETERS
//  DATA_BITS   8   data bits per frame, legal range 5..9, sent LSB first
//  FIFO_DEPTH  4   receive FIFO entries; power of 2, minimum 2
//  DIV_W      12   width of the divisor port
// PORTS
//  clk        in   1          system clock, 25 MHz
//  rst        in   1          asynchronous, active-low reset
//  RxD        in   1          serial line; asynchronous to clk, idle high
//  divisor    in   DIV_W      bit period minus 1, in clk cycles (216 = 115200 bps, 1301 = 19200 bps)
//  parity_en  in   1          1 = a parity bit follows the data bits
//  parity_odd in   1          1 = odd parity, 0 = even parity (used only when parity_en = 1)
//  two_stop   in   1          1 = two stop bits are checked
//  done       in   1          pops the FIFO head; single-cycle pulse
//  clr_ovf    in   1          clears ovf
//  rdy        out  1          FIFO not empty
//  data       out  DATA_BITS  data of the FIFO head (first-word fall-through)
//  perr       out  1          parity error of the FIFO head
//  ferr       out  1          framing error of the FIFO head
//  ovf        out  1          sticky: a frame was lost because the FIFO was full
// BEHAVIOUR
//  - Reset: state IDLE, FIFO empty, tick/bit counters cleared.
//    Outputs rdy, data, perr, ferr and ovf are all 0; the synchroniser flops reset to 1.
//  - RxD passes through a 2-flop synchroniser (s1, s2). A start edge is s2=1 & s1=0 in IDLE only.
//  - Configuration latching: divisor, parity_en, parity_odd and two_stop are latched at start-edge
//    detection. Changes mid-frame take effect on the next frame. A latched divisor < 3 is forced to 3.
//  - Timing: tick counts 0..div_l, then wraps to 0 and the bit index advances.
//    Each bit is sampled once, at tick == div_l>>1, from s2.
//  - FSM states:
//    IDLE -> START on start edge; tick is cleared.
//    START: at mid-sample, line high = false start -> IDLE with no push; low -> DATA at wrap.
//    DATA: DATA_BITS samples shifted in LSB first -> PARITY if parity_en, else STOP1.
//    PARITY: perr = (XOR of data bits ^ sample) != parity_odd.
//    STOP1: at mid-sample, ferr = ~sample. If two_stop -> STOP2 at wrap; else push and -> IDLE.
//    STOP2: at mid-sample, ferr |= ~sample; push and -> IDLE.
//  - Return to IDLE happens on the stop mid-sample cycle, not at end of bit, so a following
//    start edge 1/2 bit later is caught. After ferr with the line held low (break), no new
//    frame starts until the line returns high.
//  - Push and rdy latency: push is {ferr, perr, data} on the final stop mid-sample cycle;
//    rdy and the head outputs update on the next cycle.
//  - Pop: done & rdy removes the head; the next entry appears the following cycle.
//    done while empty is ignored.
//  - Full FIFO: a push while full and no pop drops the new frame, keeps existing entries
//    unchanged, and sets ovf. Push and pop in the same cycle when full both occur; ovf is not set.
//  - ovf: stays set until clr_ovf or reset. If clr_ovf and a new overflow occur in the same
//    cycle, ovf is left set.
//  - Pointers are log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH;
//    full = MSBs differ and lower bits are equal.
//  - When empty, data/perr/ferr hold the last popped value (0 after reset); they are only
//    valid while rdy = 1.
//  - Reset mid-frame: the FSM goes to IDLE and the FIFO is emptied immediately. The rest of
//    the interrupted frame must not produce a push; a spurious start may be rejected later as a
//    false start or framing error.
// TESTING
//  1. 8N1, divisor=216, send 0x55 -> rdy rises 1 cycle after stop mid-sample;
//     data=0x55, perr=ferr=0; done pulse -> rdy=0.
//  2. 8E1, send 0xA3 with parity bit 1 (correct is 0) -> data=0xA3, perr=1, ferr=0;
//     8O1 with bit 1 -> perr=0.
//  3. 8N2, send 0x3C with second stop bit low -> data=0x3C, ferr=1;
//     the next frame 0x81 is received clean.
//  4. RxD low for 50 cycles at divisor=216 -> no push, FSM back in IDLE; the next valid frame
//     0x7E is received.
//  5. FIFO_DEPTH=4, frames 0x01..0x05 with no pops -> ovf=1; pops return 0x01..0x04 in order,
//     then rdy=0; clr_ovf -> ovf=0.
//  6. rst low during data bit 3 -> all outputs 0 and FIFO empty;
//     after release, 7N1 divisor=1301 frame 0x2A -> data=0x2A.

Source files
------------

// File: rtl/rs232_rx_fifo_if.sv
// Read-side bus of the RS232 receive FIFO: head entry, ready flag, pop strobe and overrun flag.
// master = the bus agent that reads entries and pops them; slave = the receiver that owns the FIFO.
// Ports: done/clr_ovf (master->slave), rdy/data/perr/ferr/ovf (slave->master).
interface rs232_rx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 done;
    logic                 clr_ovf;
    logic                 rdy;
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
    logic                 ovf;

    modport master (
        output done, clr_ovf,
        input  rdy, data, perr, ferr, ovf
    );

    modport slave (
        input  done, clr_ovf,
        output rdy, data, perr, ferr, ovf
    );
endinterface

// File: rtl/rs232_rx_fifo.sv
// RS232 receiver (5..9 data bits, optional parity, 1/2 stop bits, run-time divisor) into a FIFO.
// Latency: entry visible (rdy) one cycle after the final stop-bit mid-sample; a pop shows the next entry one cycle later.
// Backpressure: none on the line; a frame arriving while the FIFO is full (and not popped) is dropped and sets sticky ovf.
//
// Ports:
//   clk, rst        clock and asynchronous active-low reset
//   RxD             serial input, asynchronous, idle high
//   divisor         bit period minus 1 in clk cycles (values below 3 behave as 3)
//   parity_en/odd   parity bit present / odd parity select
//   two_stop        check a second stop bit
//   bus (slave)     done/clr_ovf in; rdy, data, perr, ferr, ovf out (head is first-word fall-through)
module rs232_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_W      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RxD,
    input  logic [DIV_W-1:0] divisor,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             two_stop,
    rs232_rx_fifo_if.slave   bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int EW  = DATA_BITS + 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    state_t               state, state_n;
    logic                 s1, s2;
    logic [DIV_W-1:0]     tick, div_l;
    logic [BCW-1:0]       bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_r, ferr_r;
    logic                 pen_l, podd_l, two_l;

    logic start_det, mid, wrap, last_bit;
    logic cfg_load, shift_en, par_en, stop1_en, bit_clr, bit_inc;
    logic push, push_ferr;

    // Two-flop synchroniser; idle-high reset value avoids a fake start edge out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= RxD;
            s2 <= s1;
        end
    end

    assign start_det = s2 & ~s1;
    assign mid       = (tick == (div_l >> 1));
    assign wrap      = (tick == div_l);
    assign last_bit  = (bit_idx == BCW'(DATA_BITS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n   = state;
        cfg_load  = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop1_en  = 1'b0;
        bit_clr   = 1'b0;
        bit_inc   = 1'b0;
        push      = 1'b0;
        push_ferr = ferr_r;
        case (state)
            IDLE: begin
                if (start_det) begin
                    cfg_load = 1'b1;
                    state_n  = START;
                end
            end
            START: begin
                // Line back high at the start-bit centre: a glitch, not a frame.
                if (mid && s2) begin
                    state_n = IDLE;
                end else if (wrap) begin
                    bit_clr = 1'b1;
                    state_n = DATA;
                end
            end
            DATA: begin
                shift_en = mid;
                if (wrap) begin
                    if (last_bit) state_n = pen_l ? PARITY : STOP1;
                    else          bit_inc = 1'b1;
                end
            end
            PARITY: begin
                par_en = mid;
                if (wrap) state_n = STOP1;
            end
            STOP1: begin
                stop1_en  = mid;
                push_ferr = ~s2;
                // Leave on the mid-sample so a start edge half a bit later is still seen.
                if (mid && !two_l) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end else if (wrap) begin
                    state_n = STOP2;
                end
            end
            STOP2: begin
                push_ferr = ferr_r | ~s2;
                if (mid) begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick    <= '0;
            div_l   <= DIV_W'(3);
            pen_l   <= 1'b0;
            podd_l  <= 1'b0;
            two_l   <= 1'b0;
            bit_idx <= '0;
            shreg   <= '0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
        end else begin
            if (cfg_load) begin
                tick   <= '0;
                // Below 3 the mid-sample and wrap would collide with the synchroniser delay.
                div_l  <= (divisor < DIV_W'(3)) ? DIV_W'(3) : divisor;
                pen_l  <= parity_en;
                podd_l <= parity_odd;
                two_l  <= two_stop;
                perr_r <= 1'b0;
                ferr_r <= 1'b0;
            end else if (state != IDLE) begin
                tick <= wrap ? '0 : tick + DIV_W'(1);
            end
            if (bit_clr)      bit_idx <= '0;
            else if (bit_inc) bit_idx <= bit_idx + BCW'(1);
            if (shift_en) shreg  <= {s2, shreg[DATA_BITS-1:1]};
            if (par_en)   perr_r <= ((^shreg) ^ s2) != podd_l;
            if (stop1_en) ferr_r <= ~s2;
        end
    end

    // Receive FIFO: entries are {ferr, perr, data}; pointers carry one wrap bit.
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [EW-1:0] push_word, head_q, head_n;
    logic          empty, full, pop, push_ok, overflow, ovf_q;

    assign push_word = {push_ferr, perr_r, shreg};
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = bus.done & ~empty;
    assign push_ok   = push & (~full | pop);
    assign overflow  = push & full & ~pop;
    assign rd_ptr_n  = rd_ptr + (AW+1)'(pop);
    assign wr_ptr_n  = wr_ptr + (AW+1)'(push_ok);

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= push_word;
    end

    // Head register holds the last popped entry while empty; when the next head is the
    // entry being written this cycle, take it straight from the push word.
    always_comb begin
        head_n = head_q;
        if (rd_ptr_n != wr_ptr_n) begin
            if (push_ok && (rd_ptr_n == wr_ptr)) head_n = push_word;
            else                                 head_n = mem[rd_ptr_n[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            head_q <= head_n;
            // A new overrun wins over a simultaneous clear.
            if (overflow)         ovf_q <= 1'b1;
            else if (bus.clr_ovf) ovf_q <= 1'b0;
        end
    end

    assign bus.rdy = ~empty;
    assign bus.ovf = ovf_q;
    assign {bus.ferr, bus.perr, bus.data} = head_q;
endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Bench for rs232_rx_fifo: directed frames plus randomized frames/config/pops,
// checked against a queue-based model of received entries and the overrun flag.
module tb_rs232_rx_fifo;
    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [11:0] divisor;
    logic        parity_en, parity_odd, two_stop;

    rs232_rx_fifo_if #(.DATA_BITS(8)) bus8();
    rs232_rx_fifo_if #(.DATA_BITS(7)) bus7();

    rs232_rx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(12)) u_dut (
        .clk(clk), .rst(rst), .RxD(rxd), .divisor(divisor), .parity_en(parity_en),
        .parity_odd(parity_odd), .two_stop(two_stop), .bus(bus8)
    );

    rs232_rx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4), .DIV_W(12)) u_dut7 (
        .clk(clk), .rst(rst), .RxD(rxd), .divisor(divisor), .parity_en(parity_en),
        .parity_odd(parity_odd), .two_stop(two_stop), .bus(bus7)
    );

    always #20 clk = ~clk;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf;
    int   checks = 0;
    int   errors = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int bit_period();
        return ((divisor < 12'd3) ? 3 : int'(divisor)) + 1;
    endfunction

    // Expected entry from the frame's line-level content.
    function automatic ent_t expect_frame(input int nbits, input logic [8:0] d, input bit pen,
                                          input bit podd, input bit pbit, input bit st1,
                                          input bit st2, input bit two);
        ent_t e;
        int   ones = 0;
        e.data = '0;
        for (int i = 0; i < nbits; i++) begin
            e.data[i] = d[i];
            ones += int'(d[i]);
        end
        e.perr = pen && (((ones + int'(pbit)) % 2) != int'(podd));
        e.ferr = !st1 || (two && !st2);
        return e;
    endfunction

    task automatic model_push(input ent_t e);
        if (mq.size() < 4) mq.push_back(e);
        else               m_ovf = 1'b1;
    endtask

    task automatic send_frame(input int nbits, input logic [8:0] d, input bit pbit,
                              input bit st1, input bit st2);
        logic [12:0] bits;
        int n;
        int per;
        per = bit_period();
        bits = '0;
        for (int i = 0; i < nbits; i++) bits[1+i] = d[i];
        n = 1 + nbits;
        if (parity_en) begin bits[n] = pbit; n++; end
        bits[n] = st1; n++;
        if (two_stop) begin bits[n] = st2; n++; end
        @(negedge clk);
        for (int b = 0; b < n; b++) begin
            rxd = bits[b];
            repeat (per) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic rx_frame(input logic [8:0] d, input bit pbit, input bit st1, input bit st2);
        send_frame(8, d, pbit, st1, st2);
        model_push(expect_frame(8, d, parity_en, parity_odd, pbit, st1, st2, two_stop));
    endtask

    task automatic pop_check(input string tag);
        @(negedge clk);
        chk_eq({tag, ".rdy"}, 32'(bus8.rdy), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk_eq({tag, ".data"}, 32'(bus8.data), 32'(mq[0].data));
            chk_eq({tag, ".perr"}, 32'(bus8.perr), 32'(mq[0].perr));
            chk_eq({tag, ".ferr"}, 32'(bus8.ferr), 32'(mq[0].ferr));
        end
        bus8.done = 1'b1;
        @(negedge clk);
        bus8.done = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
    endtask

    task automatic clear_ovf();
        @(negedge clk);
        bus8.clr_ovf = 1'b1;
        @(negedge clk);
        bus8.clr_ovf = 1'b0;
        m_ovf = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        rxd = 1'b1;
        divisor = 12'd216;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        bus8.done = 1'b0; bus8.clr_ovf = 1'b0;
        bus7.done = 1'b0; bus7.clr_ovf = 1'b0;
        m_ovf = 1'b0;
        idle(4);
        chk_eq("reset.rdy",  32'(bus8.rdy),  0);
        chk_eq("reset.data", 32'(bus8.data), 0);
        chk_eq("reset.perr", 32'(bus8.perr), 0);
        chk_eq("reset.ferr", 32'(bus8.ferr), 0);
        chk_eq("reset.ovf",  32'(bus8.ovf),  0);
        rst = 1'b1;
        idle(4);

        // 1: 8N1 0x55, exact rdy latency counted from the first edge after the start bit.
        n = 0;
        fork
            send_frame(8, 9'h055, 1'b0, 1'b1, 1'b1);
            begin
                @(negedge rxd);
                for (int i = 0; i < 5000; i++) begin
                    @(posedge clk);
                    n++;
                    #1;
                    if (bus8.rdy) break;
                end
            end
        join
        model_push(expect_frame(8, 9'h055, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        chk_eq("t1.latency", 32'(n), 32'(3 + 9 * (216 + 1) + (216 >> 1)));
        chk_eq("t1.data", 32'(bus8.data), 32'h55);
        pop_check("t1");
        chk_eq("t1.rdy_after_pop", 32'(bus8.rdy), 0);

        // 2: 8E1 wrong parity bit, then 8O1 with the same bit.
        parity_en = 1'b1; parity_odd = 1'b0;
        rx_frame(9'h0A3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk_eq("t2.even.perr", 32'(bus8.perr), 1);
        pop_check("t2e");
        parity_odd = 1'b1;
        rx_frame(9'h0A3, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk_eq("t2.odd.perr", 32'(bus8.perr), 0);
        pop_check("t2o");

        // 3: 8N2 with bad second stop bit, then a clean frame.
        parity_en = 1'b0; two_stop = 1'b1;
        rx_frame(9'h03C, 1'b0, 1'b1, 1'b0);
        idle(50);
        @(negedge clk);
        chk_eq("t3.ferr", 32'(bus8.ferr), 1);
        pop_check("t3a");
        rx_frame(9'h081, 1'b0, 1'b1, 1'b1);
        pop_check("t3b");

        // 4: 50-cycle glitch is a false start; next frame still received.
        two_stop = 1'b0;
        @(negedge clk); rxd = 1'b0;
        idle(50);
        rxd = 1'b1;
        idle(300);
        chk_eq("t4.no_push", 32'(bus8.rdy), 0);
        rx_frame(9'h07E, 1'b0, 1'b1, 1'b1);
        pop_check("t4");
        pop_check("t4.empty_done");

        // 5: overrun with five frames into four entries.
        divisor = 12'd20;
        for (int i = 1; i <= 5; i++) rx_frame(9'(i), 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk_eq("t5.ovf", 32'(bus8.ovf), 32'(m_ovf));
        for (int i = 1; i <= 4; i++) begin
            chk_eq("t5.order", 32'(bus8.data), 32'(i));
            pop_check("t5");
        end
        chk_eq("t5.empty", 32'(bus8.rdy), 0);
        clear_ovf();
        chk_eq("t5.clr_ovf", 32'(bus8.ovf), 0);

        // Randomized frames, configs and pops.
        for (int f = 0; f < 40; f++) begin
            divisor    = 12'($urandom_range(0, 24));
            parity_en  = 1'($urandom_range(0, 1));
            parity_odd = 1'($urandom_range(0, 1));
            two_stop   = 1'($urandom_range(0, 1));
            rx_frame(9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 5) != 0, $urandom_range(0, 5) != 0);
            @(negedge clk);
            chk_eq("rnd.ovf", 32'(bus8.ovf), 32'(m_ovf));
            repeat ($urandom_range(0, 2)) pop_check("rnd");
            if ($urandom_range(0, 3) == 0) begin
                clear_ovf();
                chk_eq("rnd.clr_ovf", 32'(bus8.ovf), 0);
            end
            idle($urandom_range(1, 30));
        end

        // 6: reset during data bit 3 (line high for the rest of the frame), then 7N1 on the 7-bit unit.
        divisor = 12'd20; parity_en = 1'b0; two_stop = 1'b0;
        rx_frame(9'h099, 1'b0, 1'b1, 1'b1);
        divisor = 12'd216;
        fork
            send_frame(8, 9'h0F8, 1'b0, 1'b1, 1'b1);
            begin
                @(negedge rxd);
                repeat (4 * 217 + 100) @(negedge clk);
                rst = 1'b0;
                idle(3);
                chk_eq("t6.rdy",   32'(bus8.rdy),  0);
                chk_eq("t6.data",  32'(bus8.data), 0);
                chk_eq("t6.perr",  32'(bus8.perr), 0);
                chk_eq("t6.ferr",  32'(bus8.ferr), 0);
                chk_eq("t6.ovf",   32'(bus8.ovf),  0);
                chk_eq("t6.rdy7",  32'(bus7.rdy),  0);
                chk_eq("t6.data7", 32'(bus7.data), 0);
                chk_eq("t6.ovf7",  32'(bus7.ovf),  0);
                rst = 1'b1;
                mq.delete();
                m_ovf = 1'b0;
            end
        join
        idle(300);
        chk_eq("t6.no_push",  32'(bus8.rdy), 0);
        chk_eq("t6.no_push7", 32'(bus7.rdy), 0);
        divisor = 12'd1301;
        send_frame(7, 9'h02A, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk_eq("t6.7n1.rdy",  32'(bus7.rdy),  1);
        chk_eq("t6.7n1.data", 32'(bus7.data), 32'h2A);
        chk_eq("t6.7n1.perr", 32'(bus7.perr), 0);
        chk_eq("t6.7n1.ferr", 32'(bus7.ferr), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
